frame_capture_ctrl: RTL and testbench
=====================================

Name: frame_capture_ctrl

Overview:
Sequences capture of the HSYNC-framed pixel stream produced by the image source into a two-bank (ping-pong) frame buffer that feeds the SPIHT wavelet/encoder stage. The block counts columns and lines, generates buffer write strobes and addresses, and hands each full bank to the consumer with a ready/release handshake. When no bank is free, it drops whole frames and flags the overflow.

Parameters:
IMG_WIDTH, 512, pixels per line
IMG_HEIGHT, 512, lines per frame
DATA_W, 16, pixel width
ADDR_W, 18, per-bank address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT

Ports:
PCLK  in  1  pixel clock; the only clock
RST  in  1  reset, synchronous, active-high
HSYNC  in  1  line-valid; Pixel_DATA is valid in every cycle where HSYNC=1
Pixel_DATA  in  DATA_W  input pixel
WR_EN  out  1  buffer write strobe
WR_ADDR  out  ADDR_W+1  MSB = bank, LSBs = line*IMG_WIDTH+col
WR_DATA  out  DATA_W  write data
FRAME_RDY  out  1  at least one bank holds a complete frame
FRAME_BANK  out  1  bank to consume (oldest full bank)
FRAME_DONE  in  1  one-cycle pulse from consumer; releases FRAME_BANK
OVERFLOW  out  1  sticky: a frame was dropped
LINE_ERR  out  1  sticky: a line was not exactly IMG_WIDTH pixels
FRAME_CNT  out  8  count of frames committed; wraps 255->0

Behaviour:
- Reset applies on the PCLK edge when RST=1. Resulting values:
  - All outputs 0.
  - Both banks free; write bank = 0; state = WAIT_LINE; column and line counters 0.
- Reset mid-frame discards the partial frame and any full banks.
- Write path: sample in cycle N with HSYNC=1 and col<IMG_WIDTH -> WR_EN=1, WR_ADDR and WR_DATA valid in cycle N+1 (1-cycle registered latency). WR_EN=0 otherwise.
- States:
  - WAIT_LINE: wait for HSYNC rising edge (HSYNC=1 with previous HSYNC=0).
    - If the write bank is free -> CAPTURE.
    - If not free and line=0 -> DROP, set OVERFLOW.
  - CAPTURE: write pixels and increment col. On HSYNC falling edge:
    - col != IMG_WIDTH -> set LINE_ERR.
    - line increments and col is cleared.
    - If line reaches IMG_HEIGHT -> COMMIT, else -> WAIT_LINE.
  - COMMIT (1 cycle):
    - Mark the write bank full and increment FRAME_CNT.
    - Toggle the write bank; clear line.
    - Go to WAIT_LINE.
  - DROP: no writes. Count lines as in CAPTURE. After IMG_HEIGHT lines -> WAIT_LINE with line=0; the dropped frame does not increment FRAME_CNT.
- Pixels beyond IMG_WIDTH in one line are not written (col saturates at IMG_WIDTH) and set LINE_ERR.
- A short line leaves the missing addresses unwritten.
- FRAME_RDY = either bank full. FRAME_BANK = the older full bank; it is stable while FRAME_RDY=1.
- FRAME_DONE with FRAME_RDY=1 frees FRAME_BANK in the next cycle. FRAME_DONE with FRAME_RDY=0 is ignored.
- FRAME_DONE in the same cycle as COMMIT: both take effect. The newly committed bank becomes FRAME_BANK if the released bank was the only full one.
- A bank released in the same cycle WAIT_LINE tests it counts as free.
- The HSYNC edge detector uses a registered copy of HSYNC that resets to 0.

Optional Feature:
FCC_TESTPAT_EN
- Defined: WR_DATA = {line[7:0], col[7:0]}, zero-extended or truncated to DATA_W; Pixel_DATA is ignored. Timing and all control behaviour are unchanged.
- Undefined: WR_DATA = registered Pixel_DATA.

Decomposition:
- Shared header/package (next to macro_spiht.h):
  - state encodings WAIT_LINE / CAPTURE / COMMIT / DROP
  - NUM_BANKS=2
  - default IMG_WIDTH, IMG_HEIGHT, ADDR_W
- One sub-module: fcc_bank_tracker. It holds the two full flags and the oldest-bank pointer, with inputs commit/bank and release, and outputs FRAME_RDY, FRAME_BANK, free-of-bank.

Test Plan:
1. IMG_WIDTH=8, IMG_HEIGHT=4; one frame, pixel value = index 0..31.
   - 32 WR_EN pulses, WR_ADDR 0x00..0x1F in bank 0, WR_DATA = index.
   - FRAME_RDY=1, FRAME_BANK=0, FRAME_CNT=1 after the last line.
2. Two frames with no FRAME_DONE.
   - Second frame goes to bank 1 (WR_ADDR MSB=1).
   - A third frame causes no WR_EN, sets OVERFLOW=1, and leaves FRAME_CNT=2.
   - Then FRAME_DONE -> FRAME_BANK switches 0->1.
3. FRAME_DONE pulse in the COMMIT cycle of frame 2 while bank 0 is full.
   - Bank 0 freed, bank 1 full, FRAME_RDY stays 1, FRAME_BANK=1.
4. Line of 6 pixels, then a line of 10 pixels (IMG_WIDTH=8).
   - LINE_ERR=1.
   - 6 and 8 writes respectively.
   - Next line starts at col 0 of the following line address.
5. Assert RST for 1 cycle after 2 lines of a frame.
   - All outputs 0.
   - The next frame is written from address 0 of bank 0.
6. FCC_TESTPAT_EN defined, pixel at line 2, col 5 -> WR_DATA=0x0205.

Source files
------------

// File: rtl/frame_capture_ctrl_pkg.sv
// Shared definitions for the ping-pong frame capture controller: state encoding,
// bank count and default image geometry.
package frame_capture_ctrl_pkg;

    localparam int unsigned NUM_BANKS      = 2;
    localparam int unsigned DEF_IMG_WIDTH  = 512;
    localparam int unsigned DEF_IMG_HEIGHT = 512;
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_ADDR_W     = 18;

    typedef enum logic [1:0] {
        StWaitLine = 2'd0,
        StCapture  = 2'd1,
        StCommit   = 2'd2,
        StDrop     = 2'd3
    } fcc_state_e;

endpackage

// File: rtl/fcc_bank_tracker.sv
// Full flags and oldest-bank pointer for the two frame buffer banks; releases apply to
// the oldest full bank and may coincide with a commit.
module fcc_bank_tracker
    import frame_capture_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit,
    input  logic                 commit_bank,
    input  logic                 release_req,
    output logic                 frame_rdy,
    output logic                 frame_bank,
    output logic [NUM_BANKS-1:0] bank_free
);

    logic [NUM_BANKS-1:0] full_q, full_d;
    logic                 oldest_q, oldest_d;
    logic                 rel;

    assign frame_rdy  = |full_q;
    assign frame_bank = oldest_q;
    assign rel        = release_req & frame_rdy;

    always_comb begin
        full_d = full_q;
        if (rel) full_d[oldest_q] = 1'b0;
        if (commit) full_d[commit_bank] = 1'b1;

        // With both banks full the pointer holds, so the earlier commit stays oldest.
        oldest_d = oldest_q;
        if (full_d == 2'b01) begin
            oldest_d = 1'b0;
        end else if (full_d == 2'b10) begin
            oldest_d = 1'b1;
        end

        bank_free = ~full_q;
        if (rel) bank_free[oldest_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= '0;
            oldest_q <= 1'b0;
        end else begin
            full_q   <= full_d;
            oldest_q <= oldest_d;
        end
    end

endmodule

// File: rtl/frame_capture_ctrl.sv
// HSYNC-framed pixel capture into a ping-pong frame buffer with frame-drop on overflow.
// Define FCC_TESTPAT_EN to write a {line,col} test pattern instead of Pixel_DATA.
module frame_capture_ctrl
    import frame_capture_ctrl_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic              PCLK,
    input  logic              RST,
    input  logic              HSYNC,
    input  logic [DATA_W-1:0] Pixel_DATA,
    output logic              WR_EN,
    output logic [ADDR_W:0]   WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              FRAME_RDY,
    output logic              FRAME_BANK,
    input  logic              FRAME_DONE,
    output logic              OVERFLOW,
    output logic              LINE_ERR,
    output logic [7:0]        FRAME_CNT
);

    localparam int unsigned COL_W  = $clog2(IMG_WIDTH + 1);
    localparam int unsigned LINE_W = $clog2(IMG_HEIGHT + 1);

    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(IMG_WIDTH);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(IMG_HEIGHT - 1);

    fcc_state_e          state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                wr_bank_q, wr_bank_d;
    logic                hsync_q;
    logic                ovf_q, ovf_d;
    logic                lerr_q, lerr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                commit;
    logic                pix_ok;
    logic                rise, fall;
    logic [NUM_BANKS-1:0] bank_free;

    assign rise = HSYNC & ~hsync_q;
    assign fall = ~HSYNC & hsync_q;

    fcc_bank_tracker u_bank_tracker (
        .clk         (PCLK),
        .rst         (RST),
        .commit      (commit),
        .commit_bank (wr_bank_q),
        .release_req (FRAME_DONE),
        .frame_rdy   (FRAME_RDY),
        .frame_bank  (FRAME_BANK),
        .bank_free   (bank_free)
    );

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        line_d    = line_q;
        wr_bank_d = wr_bank_q;
        ovf_d     = ovf_q;
        lerr_d    = lerr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        commit    = 1'b0;
        pix_ok    = 1'b0;

        unique case (state_q)
            StWaitLine: begin
                // The rising-edge cycle already carries the first pixel of the line.
                if (rise) begin
                    if (bank_free[wr_bank_q]) begin
                        state_d = StCapture;
                        pix_ok  = 1'b1;
                    end else if (line_q == '0) begin
                        state_d = StDrop;
                        ovf_d   = 1'b1;
                    end
                end
            end
            StCapture: begin
                if (HSYNC) begin
                    pix_ok = 1'b1;
                end else if (hsync_q) begin
                    if (col_q != COL_MAX) lerr_d = 1'b1;
                    col_d   = '0;
                    line_d  = line_q + 1'b1;
                    state_d = (line_q == LAST_LINE) ? StCommit : StWaitLine;
                end
            end
            StCommit: begin
                commit    = 1'b1;
                cnt_d     = cnt_q + 8'd1;
                wr_bank_d = ~wr_bank_q;
                line_d    = '0;
                state_d   = StWaitLine;
            end
            StDrop: begin
                if (fall) begin
                    if (line_q == LAST_LINE) begin
                        line_d  = '0;
                        state_d = StWaitLine;
                    end else begin
                        line_d = line_q + 1'b1;
                    end
                end
            end
            default: state_d = StWaitLine;
        endcase

        if (pix_ok) begin
            if (col_q < COL_MAX) begin
                wr_en_d   = 1'b1;
                wr_addr_d = {wr_bank_q,
                             ADDR_W'(line_q) * ADDR_W'(IMG_WIDTH) + ADDR_W'(col_q)};
`ifdef FCC_TESTPAT_EN
                wr_data_d = DATA_W'({8'(line_q), 8'(col_q)});
`else
                wr_data_d = Pixel_DATA;
`endif
                col_d     = col_q + 1'b1;
            end else begin
                lerr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (RST) begin
            state_q   <= StWaitLine;
            col_q     <= '0;
            line_q    <= '0;
            wr_bank_q <= 1'b0;
            hsync_q   <= 1'b0;
            ovf_q     <= 1'b0;
            lerr_q    <= 1'b0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            line_q    <= line_d;
            wr_bank_q <= wr_bank_d;
            hsync_q   <= HSYNC;
            ovf_q     <= ovf_d;
            lerr_q    <= lerr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign WR_EN     = wr_en_q;
    assign WR_ADDR   = wr_addr_q;
    assign WR_DATA   = wr_data_q;
    assign OVERFLOW  = ovf_q;
    assign LINE_ERR  = lerr_q;
    assign FRAME_CNT = cnt_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Self-checking bench for frame_capture_ctrl on an 8x4 image, using a frame-level model
// of bank occupancy (FIFO of full banks) and expected buffer writes.
module tb_frame_capture_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 5;
    localparam int DW = 16;

    logic          PCLK = 1'b0;
    logic          RST;
    logic          HSYNC;
    logic [DW-1:0] Pixel_DATA;
    logic          WR_EN;
    logic [AW:0]   WR_ADDR;
    logic [DW-1:0] WR_DATA;
    logic          FRAME_RDY;
    logic          FRAME_BANK;
    logic          FRAME_DONE;
    logic          OVERFLOW;
    logic          LINE_ERR;
    logic [7:0]    FRAME_CNT;

    frame_capture_ctrl #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_W     (DW),
        .ADDR_W     (AW)
    ) dut (
        .PCLK       (PCLK),
        .RST        (RST),
        .HSYNC      (HSYNC),
        .Pixel_DATA (Pixel_DATA),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .FRAME_RDY  (FRAME_RDY),
        .FRAME_BANK (FRAME_BANK),
        .FRAME_DONE (FRAME_DONE),
        .OVERFLOW   (OVERFLOW),
        .LINE_ERR   (LINE_ERR),
        .FRAME_CNT  (FRAME_CNT)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW:0]   obs_addr[$];
    logic [DW-1:0] obs_data[$];
    logic [AW:0]   exp_addr[$];
    logic [DW-1:0] exp_data[$];

    // Reference model: write bank, full flags and age-ordered list of full banks.
    int m_wbank;
    bit m_full[2];
    int m_fifo[$];
    int m_cnt;
    bit m_ovf;
    bit m_lerr;
    int lens[H];

    always @(negedge PCLK) begin
        if (WR_EN === 1'b1) begin
            obs_addr.push_back(WR_ADDR);
            obs_data.push_back(WR_DATA);
        end
    end

    task automatic model_release();
        int b;
        if (m_fifo.size() > 0) begin
            b = m_fifo.pop_front();
            m_full[b] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        RST = 1'b1; HSYNC = 1'b0; FRAME_DONE = 1'b0;
        @(negedge PCLK);
        RST = 1'b0;
        m_wbank = 0; m_full[0] = 0; m_full[1] = 0; m_fifo.delete();
        m_cnt = 0; m_ovf = 0; m_lerr = 0;
        obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
    endtask

    task automatic do_release();
        @(negedge PCLK);
        FRAME_DONE = 1'b1;
        @(negedge PCLK);
        FRAME_DONE = 1'b0;
        model_release();
    endtask

    // Sends nlines lines with lengths from lens[]; optionally pulses FRAME_DONE in the
    // cycle where the final line's commit lands.
    task automatic send_frame(input int nlines, input bit idx_data, input bit done_at_commit);
        bit cap;
        logic [DW-1:0] pix;
        cap = !m_full[m_wbank];
        if (!cap) m_ovf = 1'b1;
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c < lens[l]; c++) begin
                @(negedge PCLK);
                pix = idx_data ? DW'(l * W + c) : DW'($urandom);
                HSYNC = 1'b1;
                Pixel_DATA = pix;
                if (cap && c < W) begin
                    exp_addr.push_back({1'(m_wbank), AW'(l * W + c)});
`ifdef FCC_TESTPAT_EN
                    exp_data.push_back(DW'({8'(l), 8'(c)}));
`else
                    exp_data.push_back(pix);
`endif
                end
            end
            @(negedge PCLK);
            HSYNC = 1'b0;
            if (cap && lens[l] != W) m_lerr = 1'b1;
            @(negedge PCLK);
            if (done_at_commit && l == H - 1) FRAME_DONE = 1'b1;
            @(negedge PCLK);
            FRAME_DONE = 1'b0;
            @(negedge PCLK);
        end
        if (done_at_commit && nlines == H) model_release();
        if (cap && nlines == H) begin
            m_full[m_wbank] = 1'b1;
            m_fifo.push_back(m_wbank);
            m_cnt = (m_cnt + 1) % 256;
            m_wbank ^= 1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; HSYNC = 1'b0; FRAME_DONE = 1'b0; Pixel_DATA = '0;
        repeat (3) @(negedge PCLK);
        do_reset();
        n_cmp++;
        if ({WR_EN, WR_ADDR, WR_DATA, FRAME_RDY, FRAME_BANK, OVERFLOW, LINE_ERR, FRAME_CNT}
            !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got en=%b addr=%h data=%h rdy=%b bank=%b ovf=%b lerr=%b cnt=%0d want all 0",
                     WR_EN, WR_ADDR, WR_DATA, FRAME_RDY, FRAME_BANK, OVERFLOW, LINE_ERR, FRAME_CNT);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        lens = '{W, W, W, W};
        send_frame(H, 1'b1, 1'b0);
        n_cmp++;
        if (obs_addr.size() != exp_addr.size()) begin
            n_bad++;
            $display("FAIL single_wr_count: got %0d want %0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                n_bad++;
                $display("FAIL single_wr[%0d]: got addr=%h data=%h want addr=%h data=%h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (FRAME_RDY !== 1'b1 || FRAME_BANK !== 1'b0 || FRAME_CNT !== 8'd1) begin
            n_bad++;
            $display("FAIL single_status: got rdy=%b bank=%b cnt=%0d want rdy=1 bank=0 cnt=1",
                     FRAME_RDY, FRAME_BANK, FRAME_CNT);
        end
        obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
    endtask

    task automatic test_overflow();
        do_reset();
        lens = '{W, W, W, W};
        send_frame(H, 1'b0, 1'b0);
        send_frame(H, 1'b0, 1'b0);
        send_frame(H, 1'b0, 1'b0);
        n_cmp++;
        if (obs_addr.size() != exp_addr.size()) begin
            n_bad++;
            $display("FAIL ovf_wr_count: got %0d want %0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                n_bad++;
                $display("FAIL ovf_wr[%0d]: got addr=%h data=%h want addr=%h data=%h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (OVERFLOW !== m_ovf || FRAME_CNT !== 8'(m_cnt) || FRAME_BANK !== 1'(m_fifo[0])) begin
            n_bad++;
            $display("FAIL ovf_status: got ovf=%b cnt=%0d bank=%b want ovf=%b cnt=%0d bank=%0d",
                     OVERFLOW, FRAME_CNT, FRAME_BANK, m_ovf, m_cnt, m_fifo[0]);
        end
        do_release();
        n_cmp++;
        if (FRAME_RDY !== 1'b1 || FRAME_BANK !== 1'(m_fifo[0])) begin
            n_bad++;
            $display("FAIL ovf_release: got rdy=%b bank=%b want rdy=1 bank=%0d",
                     FRAME_RDY, FRAME_BANK, m_fifo[0]);
        end
        obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
    endtask

    task automatic test_done_in_commit();
        do_reset();
        lens = '{W, W, W, W};
        send_frame(H, 1'b0, 1'b0);
        send_frame(H, 1'b0, 1'b1);
        n_cmp++;
        if (FRAME_RDY !== 1'b1 || FRAME_BANK !== 1'(m_fifo[0]) || m_fifo.size() != 1) begin
            n_bad++;
            $display("FAIL commit_release: got rdy=%b bank=%b want rdy=1 bank=%0d (%0d full)",
                     FRAME_RDY, FRAME_BANK, m_fifo[0], m_fifo.size());
        end
        // Bank 0 was released, so a third frame must land there rather than drop.
        send_frame(H, 1'b0, 1'b0);
        n_cmp++;
        if (obs_addr.size() != exp_addr.size() || OVERFLOW !== 1'b0) begin
            n_bad++;
            $display("FAIL commit_wr_count: got %0d ovf=%b want %0d ovf=0",
                     obs_addr.size(), OVERFLOW, exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                n_bad++;
                $display("FAIL commit_wr[%0d]: got addr=%h data=%h want addr=%h data=%h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
    endtask

    task automatic test_line_errors();
        do_reset();
        lens = '{6, 10, W, W};
        send_frame(H, 1'b0, 1'b0);
        n_cmp++;
        if (obs_addr.size() != exp_addr.size() || exp_addr.size() != 6 + 8 + 2 * W) begin
            n_bad++;
            $display("FAIL lerr_wr_count: got %0d want %0d", obs_addr.size(), 6 + 8 + 2 * W);
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                n_bad++;
                $display("FAIL lerr_wr[%0d]: got addr=%h data=%h want addr=%h data=%h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (LINE_ERR !== 1'b1 || FRAME_CNT !== 8'd1) begin
            n_bad++;
            $display("FAIL lerr_status: got lerr=%b cnt=%0d want lerr=1 cnt=1", LINE_ERR, FRAME_CNT);
        end
        obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
    endtask

    task automatic test_mid_frame_reset();
        do_reset();
        lens = '{W, 3, W, W};
        send_frame(H, 1'b0, 1'b0);
        send_frame(2, 1'b0, 1'b0);
        do_reset();
        n_cmp++;
        if ({WR_EN, WR_ADDR, WR_DATA, FRAME_RDY, FRAME_BANK, OVERFLOW, LINE_ERR, FRAME_CNT}
            !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got en=%b addr=%h rdy=%b bank=%b ovf=%b lerr=%b cnt=%0d want all 0",
                     WR_EN, WR_ADDR, FRAME_RDY, FRAME_BANK, OVERFLOW, LINE_ERR, FRAME_CNT);
        end
        lens = '{W, W, W, W};
        send_frame(H, 1'b0, 1'b0);
        n_cmp++;
        if (obs_addr.size() != exp_addr.size() || obs_addr.size() == 0 || obs_addr[0] !== '0) begin
            n_bad++;
            $display("FAIL midreset_restart: got %0d writes first addr=%h want %0d writes from 0",
                     obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : '1, exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                n_bad++;
                $display("FAIL midreset_wr[%0d]: got addr=%h data=%h want addr=%h data=%h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 2) == 0) do_release();
            for (int l = 0; l < H; l++) begin
                lens[l] = (!m_full[m_wbank] && $urandom_range(0, 3) == 0) ?
                          int'($urandom_range(1, 12)) : W;
            end
            send_frame(H, 1'b0, $urandom_range(0, 3) == 0);
            n_cmp++;
            if (obs_addr.size() != exp_addr.size()) begin
                n_bad++;
                $display("FAIL rand%0d_wr_count: got %0d want %0d",
                         it, obs_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
                n_cmp++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    n_bad++;
                    $display("FAIL rand%0d_wr[%0d]: got addr=%h data=%h want addr=%h data=%h",
                             it, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
                end
            end
            n_cmp++;
            if (FRAME_RDY !== (m_fifo.size() > 0) || FRAME_CNT !== 8'(m_cnt) ||
                OVERFLOW !== m_ovf || LINE_ERR !== m_lerr ||
                (m_fifo.size() > 0 && FRAME_BANK !== 1'(m_fifo[0]))) begin
                n_bad++;
                $display("FAIL rand%0d_status: got rdy=%b bank=%b cnt=%0d ovf=%b lerr=%b want rdy=%0d bank=%0d cnt=%0d ovf=%b lerr=%b",
                         it, FRAME_RDY, FRAME_BANK, FRAME_CNT, OVERFLOW, LINE_ERR,
                         m_fifo.size() > 0, (m_fifo.size() > 0) ? m_fifo[0] : 0,
                         m_cnt, m_ovf, m_lerr);
            end
            obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
        end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        lens = '{W, W, W, W};
        for (int f = 0; f < 257; f++) begin
            send_frame(H, 1'b0, 1'b0);
            do_release();
            obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
        end
        n_cmp++;
        if (FRAME_CNT !== 8'(m_cnt) || OVERFLOW !== 1'b0 || FRAME_RDY !== 1'b0) begin
            n_bad++;
            $display("FAIL cnt_wrap: got cnt=%0d ovf=%b rdy=%b want cnt=%0d ovf=0 rdy=0",
                     FRAME_CNT, OVERFLOW, FRAME_RDY, m_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_done_in_commit();
        test_line_errors();
        test_mid_frame_reset();
        test_random();
        test_cnt_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
